// File: rtl/mips_pkg.sv
// Shared constants for the EX-stage ALU control and the iterative mul/div unit.
package mips_pkg;

    // ALU operation codes driven to the EX-stage ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Main-control ALU op classes
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;

    // R-type funct codes
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // EX result mux selections
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_HI  = 2'b01;
    localparam logic [1:0] RES_LO  = 2'b10;

    // Multiply/divide unit sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one bit per cycle shift-add multiply
// and restoring divide on operand magnitudes, with sign fix-up into HI/LO.
module mdu_iter
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [1:0]        op_i,      // bit1: divide, bit0: unsigned
    input  logic [DATA_W-1:0] opA_i,
    input  logic [DATA_W-1:0] opB_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    mdu_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*DATA_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]       opnd_q, opnd_d;
    logic                    negLo_q, negLo_d;
    logic                    negHi_q, negHi_d;
    logic [DATA_W-1:0]       hi_q, hi_d;
    logic [DATA_W-1:0]       lo_q, lo_d;
    logic                    done_q, done_d;

    logic                    signA, signB;
    logic [DATA_W-1:0]       magA, magB;
    logic [DATA_W:0]         mulSum;
    logic [2*DATA_W-1:0]     mulNext;
    logic [DATA_W:0]         divShift;
    logic                    divGe;
    logic [DATA_W-1:0]       divDiff;
    logic [DATA_W-1:0]       divRem;
    logic [2*DATA_W-1:0]     divNext;
    logic [2*DATA_W-1:0]     accNext;
    logic [2*DATA_W-1:0]     fixed;

    // Operand magnitudes and one iteration step of each algorithm
    always_comb begin
        signA    = ~op_i[0] & opA_i[DATA_W-1];
        signB    = ~op_i[0] & opB_i[DATA_W-1];
        magA     = signA ? -opA_i : opA_i;
        magB     = signB ? -opB_i : opB_i;
        mulSum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mulNext  = {mulSum, acc_q[DATA_W-1:1]};
        divShift = acc_q[2*DATA_W-1:DATA_W-1];
        divGe    = divShift >= {1'b0, opnd_q};
        divDiff  = divShift[DATA_W-1:0] - opnd_q;
        divRem   = divGe ? divDiff : divShift[DATA_W-1:0];
        divNext  = {divRem, acc_q[DATA_W-2:0], divGe};
        accNext  = (state_q == DIV) ? divNext : mulNext;
    end

    // Sign correction applied to the result of the final iteration
    always_comb begin
        fixed = '0;
        if (state_q == DIV) begin
            fixed = {negHi_q ? -accNext[2*DATA_W-1:DATA_W] : accNext[2*DATA_W-1:DATA_W],
                     negLo_q ? -accNext[DATA_W-1:0]        : accNext[DATA_W-1:0]};
        end else begin
            fixed = negLo_q ? -accNext : accNext;
        end
    end

    // Sequencing: latch operands on start, iterate DATA_W times, write HI/LO
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        negLo_d = negLo_q;
        negHi_d = negHi_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d   = '0;
                    negLo_d = signA ^ signB;
                    negHi_d = signA;
                    if (op_i[1]) begin
                        state_d = DIV;
                        acc_d   = {{DATA_W{1'b0}}, magA};
                        opnd_d  = magB;
                    end else begin
                        state_d = MUL;
                        acc_d   = {{DATA_W{1'b0}}, magB};
                        opnd_d  = magA;
                    end
                end
            end
            MUL, DIV: begin
                acc_d = accNext;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d      = IDLE;
                    {hi_d, lo_d} = fixed;
                    done_d       = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            negLo_q <= 1'b0;
            negHi_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            negLo_q <= negLo_d;
            negHi_q <= negHi_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decoder with an attached iterative multiply/divide
// unit; stalls the pipeline while a multi-cycle operation runs.
module alu_control_mdu
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [1:0]        aluOp,
    input  logic [5:0]        fuct_field,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    output logic [CODE_W-1:0] aluCode,
    output logic [1:0]        resSel,
    output logic              stall,
    output logic              illegal,
    output logic              mduBusy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic [3:0] code;
    logic       badOp;
    logic       isMdu;
    logic       start;
    logic       doneQ;
    logic       illegal_q, illegal_d;

    // Combinational decode of op class and funct into ALU code and result select
    always_comb begin
        code   = ALU_ADD;
        resSel = RES_ALU;
        badOp  = 1'b0;
        isMdu  = 1'b0;
        case (aluOp)
            AOP_ADD: code = ALU_ADD;
            AOP_SUB: code = ALU_SUB;
            AOP_RTYPE: begin
                case (fuct_field)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_NOR:  code = ALU_NOR;
                    FN_SLT:  code = ALU_SLT;
                    FN_MFHI: resSel = RES_HI;
                    FN_MFLO: resSel = RES_LO;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: isMdu = 1'b1;
                    default: badOp = 1'b1;
                endcase
            end
            default: badOp = 1'b1;
        endcase
    end

    // doneQ blocks the still-held instruction from restarting the unit
    assign start   = ~mduBusy & valid_in & isMdu & ~doneQ;
    assign stall   = start | mduBusy;
    assign aluCode = CODE_W'(code);

    assign illegal_d = valid_in & badOp;

    // One-cycle registered flag for an undecodable instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;

    mdu_iter #(
        .DATA_W(DATA_W)
    ) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start),
        .op_i   (fuct_field[1:0]),
        .opA_i  (opA),
        .opB_i  (opB),
        .busy_o (mduBusy),
        .done_o (doneQ),
        .hi_o   (hi),
        .lo_o   (lo)
    );

endmodule
